// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the multiplier request/response sequencer.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        READ    = 3'd5,
        RESP    = 3'd6
    } seqState_e;

    localparam int CNT_WIDTH = 4;

    // Accept-to-response cycles excluding the settle phase and optional clear.
    localparam int LAT_BASE = 4;

endpackage

// File: rtl/mul_seq_enable_decode.sv
// Moore decode of sequencer state into the multiplier register enables/resets.
module mul_seq_enable_decode
    import mul_seq_pkg::*;
(
    input  seqState_e state,
    input  logic      unusedTie,
    output logic      writeEnableA,
    output logic      writeEnableB,
    output logic      writeEnableOut,
    output logic      readEnableA,
    output logic      readEnableB,
    output logic      readEnableOut,
    output logic      resetA,
    output logic      resetB,
    output logic      resetOut
);

    always_comb begin
        writeEnableA   = 1'b0;
        writeEnableB   = 1'b0;
        writeEnableOut = 1'b0;
        readEnableA    = 1'b0;
        readEnableB    = 1'b0;
        readEnableOut  = 1'b0;
        resetA         = 1'b0;
        resetB         = 1'b0;
        resetOut       = 1'b0;
        case (state)
            CLEAR: begin
                resetA   = 1'b1;
                resetB   = 1'b1;
                resetOut = 1'b1;
            end
            LOAD: begin
                writeEnableA = 1'b1;
                writeEnableB = 1'b1;
            end
            SETTLE: begin
                readEnableA = 1'b1;
                readEnableB = 1'b1;
            end
            // Operands stay readable while the result register captures them.
            CAPTURE: begin
                readEnableA    = 1'b1;
                readEnableB    = 1'b1;
                writeEnableOut = 1'b1;
            end
            READ:    readEnableOut = 1'b1;
            default: ;
        endcase
    end

    logic unusedOk;
    assign unusedOk = unusedTie;

endmodule

// File: rtl/mul_reg_sequencer.sv
// Request/response front end that walks the register-wrapped multiplier
// through clear, load, settle, capture and read for each operand pair.
module mul_reg_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SETTLE_CYCLES  = 1,   // legal range 1..15
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [WIDTH-1:0] reqA,
    input  logic [WIDTH-1:0] reqB,
    output logic             respValid,
    input  logic             respReady,
    output logic [WIDTH-1:0] respProduct,
    output logic             respOverflow,
    output logic             respError,
    output logic             busy,
    output logic [WIDTH-1:0] mulA,
    output logic [WIDTH-1:0] mulB,
    output logic             writeEnableA,
    output logic             writeEnableB,
    output logic             writeEnableOut,
    output logic             readEnableA,
    output logic             readEnableB,
    output logic             readEnableOut,
    output logic             resetA,
    output logic             resetB,
    output logic             resetOut,
    input  logic [WIDTH-1:0] mulProduct,
    input  logic             mulOverflow,
    input  logic             accessErrorA,
    input  logic             accessErrorB,
    input  logic             accessErrorOut
);

    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    seqState_e            stateReg, stateNext;
    logic [CNT_WIDTH-1:0] cntReg, cntNext;
    logic [WIDTH-1:0]     opAReg, opBReg, productReg;
    logic                 overflowReg, errorReg;
    logic                 accept, inSeq, accessError;

    assign accept      = reqValid && (stateReg == IDLE);
    assign accessError = accessErrorA | accessErrorB | accessErrorOut;
    assign inSeq       = (stateReg == CLEAR) || (stateReg == LOAD) || (stateReg == SETTLE) ||
                         (stateReg == CAPTURE) || (stateReg == READ);

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            IDLE:    if (accept) stateNext = CLEAR_ON_START ? CLEAR : LOAD;
            CLEAR:   stateNext = LOAD;
            LOAD: begin
                stateNext = SETTLE;
                cntNext   = SETTLE_LOAD;
            end
            SETTLE: begin
                if (cntReg == '0) stateNext = CAPTURE;
                else              cntNext   = cntReg - CNT_ONE;
            end
            CAPTURE: stateNext = READ;
            READ:    stateNext = RESP;
            RESP:    if (respReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // A register access fault short-circuits straight to the response.
        if (inSeq && accessError) stateNext = RESP;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            opAReg      <= '0;
            opBReg      <= '0;
            productReg  <= '0;
            overflowReg <= 1'b0;
            errorReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (accept) begin
                opAReg   <= reqA;
                opBReg   <= reqB;
                errorReg <= 1'b0;
            end
            if (inSeq && accessError) begin
                errorReg    <= 1'b1;
                productReg  <= '0;
                overflowReg <= 1'b0;
            end else begin
                if (stateReg == CAPTURE) overflowReg <= mulOverflow;
                if (stateReg == READ)    productReg  <= mulProduct;
            end
        end
    end

    assign reqReady     = (stateReg == IDLE);
    assign respValid    = (stateReg == RESP);
    assign busy         = (stateReg != IDLE);
    assign respProduct  = productReg;
    assign respOverflow = overflowReg;
    assign respError    = errorReg;
    assign mulA         = opAReg;
    assign mulB         = opBReg;

    mul_seq_enable_decode uDecode (
        .state          (stateReg),
        .unusedTie      (1'b0),
        .writeEnableA   (writeEnableA),
        .writeEnableB   (writeEnableB),
        .writeEnableOut (writeEnableOut),
        .readEnableA    (readEnableA),
        .readEnableB    (readEnableB),
        .readEnableOut  (readEnableOut),
        .resetA         (resetA),
        .resetB         (resetB),
        .resetOut       (resetOut)
    );

endmodule

// File: tb/tb_mul_reg_sequencer.sv
// Randomized self-checking bench: two sequencer configurations, each driving a
// behavioural register-wrapped multiplier, checked against a spec-level model.
module tb_mul_reg_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    logic         reqValid [2], reqReady [2], respValid [2], respReady [2];
    logic [W-1:0] reqA [2], reqB [2], respProduct [2], mulA [2], mulB [2], mulProduct [2];
    logic         respOverflow [2], respError [2], busy [2], mulOverflow [2];
    logic         weA [2], weB [2], weOut [2], reA [2], reB [2], reOut [2];
    logic         rsA [2], rsB [2], rsOut [2], aeA [2], aeB [2], aeOut [2];

    int checkCnt = 0;
    int passCnt  = 0;

    mul_reg_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1), .CLEAR_ON_START(1'b1)) dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid[0]), .reqReady(reqReady[0]), .reqA(reqA[0]), .reqB(reqB[0]),
        .respValid(respValid[0]), .respReady(respReady[0]), .respProduct(respProduct[0]),
        .respOverflow(respOverflow[0]), .respError(respError[0]), .busy(busy[0]),
        .mulA(mulA[0]), .mulB(mulB[0]),
        .writeEnableA(weA[0]), .writeEnableB(weB[0]), .writeEnableOut(weOut[0]),
        .readEnableA(reA[0]), .readEnableB(reB[0]), .readEnableOut(reOut[0]),
        .resetA(rsA[0]), .resetB(rsB[0]), .resetOut(rsOut[0]),
        .mulProduct(mulProduct[0]), .mulOverflow(mulOverflow[0]),
        .accessErrorA(aeA[0]), .accessErrorB(aeB[0]), .accessErrorOut(aeOut[0])
    );

    mul_reg_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3), .CLEAR_ON_START(1'b0)) dutP (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid[1]), .reqReady(reqReady[1]), .reqA(reqA[1]), .reqB(reqB[1]),
        .respValid(respValid[1]), .respReady(respReady[1]), .respProduct(respProduct[1]),
        .respOverflow(respOverflow[1]), .respError(respError[1]), .busy(busy[1]),
        .mulA(mulA[1]), .mulB(mulB[1]),
        .writeEnableA(weA[1]), .writeEnableB(weB[1]), .writeEnableOut(weOut[1]),
        .readEnableA(reA[1]), .readEnableB(reB[1]), .readEnableOut(reOut[1]),
        .resetA(rsA[1]), .resetB(rsB[1]), .resetOut(rsOut[1]),
        .mulProduct(mulProduct[1]), .mulOverflow(mulOverflow[1]),
        .accessErrorA(aeA[1]), .accessErrorB(aeB[1]), .accessErrorOut(aeOut[1])
    );

    // Behavioural multiplier with operand/result registers.
    logic [W-1:0] regA [2], regB [2], regOut [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rsA[k])      regA[k] <= '0;
            else if (weA[k]) regA[k] <= mulA[k];
            if (rsB[k])      regB[k] <= '0;
            else if (weB[k]) regB[k] <= mulB[k];
            if (rsOut[k])        regOut[k] <= '0;
            else if (weOut[k])   regOut[k] <= regA[k] * regB[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mulOverflow[k] = ((({32'b0, regA[k]} * {32'b0, regB[k]}) >> W) != 64'd0);
            mulProduct[k]  = reOut[k] ? regOut[k] : '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [8:0] enVec(input int i);
        return {rsA[i], rsB[i], rsOut[i], weA[i], weB[i], weOut[i], reA[i], reB[i], reOut[i]};
    endfunction

    function automatic bit clrOf(input int i);
        return (i == 0);
    endfunction

    function automatic int settleOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Expected {resets, writes, reads} at cycle k after the accept edge.
    function automatic logic [8:0] expPat(input int k, input bit clr, input int s);
        int c;
        c = k;
        if (clr) begin
            if (c == 1) return 9'b111_000_000;
            c = c - 1;
        end
        if (c == 1) return 9'b000_110_000;
        if (c >= 2 && c <= 1 + s) return 9'b000_000_110;
        if (c == 2 + s) return 9'b000_001_110;
        if (c == 3 + s) return 9'b000_000_001;
        return 9'b0;
    endfunction

    task automatic waitReady(input int i, input string tag);
        for (int n = 0; n < 20 && reqReady[i] !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        chk({tag, ".ready"}, reqReady[i], 1'b1);
    endtask

    task automatic runTxn(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit injErr, input string tag);
        logic [63:0]  full;
        logic [W-1:0] eProd;
        logic         eOv, eErr;
        logic [8:0]   v;
        int           k, errCyc, eLat;
        full = {32'b0, a} * {32'b0, b};
        waitReady(i, tag);
        reqA[i] = a; reqB[i] = b; reqValid[i] = 1'b1;
        @(posedge clk); #1;
        reqValid[i] = 1'b0; reqA[i] = $urandom; reqB[i] = $urandom;
        k = 1; errCyc = -1;
        while (respValid[i] !== 1'b1 && k < 40) begin
            v = enVec(i);
            if (!injErr) chk($sformatf("%s.pat%0d", tag, k), v, expPat(k, clrOf(i), settleOf(i)));
            chk($sformatf("%s.rw%0d", tag, k),
                (weA[i] & reA[i]) | (weB[i] & reB[i]) | (weOut[i] & reOut[i]), 1'b0);
            chk($sformatf("%s.opA%0d", tag, k), mulA[i], a);
            chk($sformatf("%s.opB%0d", tag, k), mulB[i], b);
            if (injErr && errCyc < 0 && reB[i] && !weOut[i]) begin
                aeB[i] = 1'b1; errCyc = k;
            end else begin
                aeB[i] = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        aeB[i] = 1'b0;
        eErr  = injErr && (errCyc >= 0);
        eProd = eErr ? '0 : full[W-1:0];
        eOv   = eErr ? 1'b0 : (full[63:32] != 32'd0);
        eLat  = eErr ? errCyc + 1 : (clrOf(i) ? 5 : 4) + settleOf(i);
        chk({tag, ".lat"}, k, eLat);
        for (int h = 0; h <= hold; h++) begin
            chk($sformatf("%s.valid%0d", tag, h), respValid[i], 1'b1);
            chk($sformatf("%s.prod%0d", tag, h), respProduct[i], eProd);
            chk($sformatf("%s.ovf%0d", tag, h), respOverflow[i], eOv);
            chk($sformatf("%s.err%0d", tag, h), respError[i], eErr);
            chk($sformatf("%s.rdyLow%0d", tag, h), reqReady[i], 1'b0);
            if (h < hold) begin
                reqValid[i] = 1'b1; reqA[i] = $urandom; reqB[i] = $urandom;
                @(posedge clk); #1;
            end
        end
        reqValid[i] = 1'b0;
        respReady[i] = 1'b1;
        @(posedge clk); #1;
        respReady[i] = 1'b0;
        chk({tag, ".done"}, respValid[i], 1'b0);
        chk({tag, ".idle"}, reqReady[i], 1'b1);
        $display("txn %s inst=%0d a=%0h b=%0h prod=%0h ovf=%0b err=%0b lat=%0d",
                 tag, i, a, b, respProduct[i], respOverflow[i], respError[i], k);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0; respReady[i] = 1'b0; reqA[i] = '0; reqB[i] = '0;
            aeA[i] = 1'b0; aeB[i] = 1'b0; aeOut[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d.ready", i), reqReady[i], 1'b1);
            chk($sformatf("rst%0d.valid", i), respValid[i], 1'b0);
            chk($sformatf("rst%0d.busy", i), busy[i], 1'b0);
            chk($sformatf("rst%0d.en", i), enVec(i), 9'b0);
            chk($sformatf("rst%0d.prod", i), respProduct[i], 0);
            chk($sformatf("rst%0d.mulA", i), mulA[i], 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) resetN = 1'b1;
        @(posedge clk); #1;

        runTxn(0, 32'd3, 32'd7, 0, 1'b0, "basic");
        runTxn(0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, "ovf1");
        runTxn(0, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, "ovf2");
        runTxn(0, 32'd11, 32'd13, 5, 1'b0, "bp");
        runTxn(0, 32'd123, 32'd456, 0, 1'b1, "err");
        runTxn(0, 32'd2, 32'd5, 0, 1'b0, "postErr");

        // Abort a request in CAPTURE with an asynchronous reset.
        waitReady(0, "abort");
        reqA[0] = 32'd9; reqB[0] = 32'd9; reqValid[0] = 1'b1;
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        for (int n = 0; n < 20 && weOut[0] !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        chk("abort.inCapture", weOut[0], 1'b1);
        #2 resetN = 1'b0;
        #1;
        chk("abort.en", enVec(0), 9'b0);
        chk("abort.valid", respValid[0], 1'b0);
        chk("abort.ready", reqReady[0], 1'b1);
        chk("abort.busy", busy[0], 1'b0);
        @(negedge clk) resetN = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            chk($sformatf("abort.noResp%0d", n), respValid[0], 1'b0);
        end
        runTxn(0, 32'd4, 32'd4, 0, 1'b0, "fresh");

        runTxn(1, 32'd6, 32'd9, 0, 1'b0, "param");
        runTxn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, "paramOvf");
        runTxn(1, 32'd77, 32'd3, 0, 1'b1, "paramErr");

        for (int r = 0; r < 24; r++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            runTxn(r % 2, ra, rb, $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                   $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/mul_reg_sequencer.md
Name: mul_reg_sequencer

Overview:
- Initiator-side controller for the register-wrapped 32-bit multiplier: drives its operand/result register enables, resets and data inputs, and turns them into a single request/response handshake.
- Accepts an operand pair, sequences clear → load → settle → capture → read, returns product, overflow and error status.
- Sits between a bus/test-harness master and the integrated multiplier.

Parameters:
- WIDTH, 32, operand and product width.
- SETTLE_CYCLES, 1, cycles readEnableA/B are held before result capture; legal range 1..15.
- CLEAR_ON_START, 1, when 1 the three multiplier registers are reset before each load.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  1  request valid.
- reqReady  out  1  request accepted when reqValid && reqReady.
- reqA  in  WIDTH  operand A.
- reqB  in  WIDTH  operand B.
- respValid  out  1  response valid.
- respReady  in  1  response consumed when respValid && respReady.
- respProduct  out  WIDTH  product, or 0 on error.
- respOverflow  out  1  multiplier overflow flag.
- respError  out  1  access error seen during the sequence.
- busy  out  1  state != IDLE.
- mulA, mulB  out  WIDTH  to multiplier a/b.
- writeEnableA, writeEnableB, writeEnableOut  out  1 each  register write enables.
- readEnableA, readEnableB, readEnableOut  out  1 each  register read enables.
- resetA, resetB, resetOut  out  1 each  register resets, active-high.
- mulProduct  in  WIDTH  multiplier product.
- mulOverflow  in  1  multiplier overflow.
- accessErrorA, accessErrorB, accessErrorOut  in  1 each  register access errors.

Behaviour:
- Reset (resetN=0, asynchronous): state=IDLE; every output is 0 except reqReady=1. Operand, result and error registers clear to 0. Enables drop immediately, including mid-sequence; no response is produced for an aborted request.
- States are IDLE, CLEAR, LOAD, SETTLE, CAPTURE, READ, RESP. Enables are Moore outputs decoded from state.
- IDLE: reqReady=1. On accept, latch reqA/reqB into opA/opB, clear the sticky error, and go to CLEAR (CLEAR_ON_START=1) or LOAD.
- CLEAR: resetA=resetB=resetOut=1 for 1 cycle, then LOAD.
- LOAD: writeEnableA=writeEnableB=1 for 1 cycle, then SETTLE.
- SETTLE: readEnableA=readEnableB=1. A 4-bit down-counter loads SETTLE_CYCLES-1 on entry. Exit to CAPTURE when the counter is 0.
- CAPTURE: readEnableA=readEnableB=1 and writeEnableOut=1 for 1 cycle. Latch mulOverflow into respOverflow. Next state READ.
- READ: readEnableOut=1 for 1 cycle. Latch mulProduct into respProduct. Next state RESP.
- RESP: respValid=1, holding respProduct/respOverflow/respError stable until respReady. When the handshake completes, go to IDLE (reqReady asserts the next cycle; no back-to-back accept in RESP).
- mulA/mulB are driven from opA/opB at all times, so they are stable from LOAD through READ.
- The sequencer never asserts read and write enables of the same register in the same cycle.
- Errors: any accessError* high in CLEAR..READ sets the sticky error. The FSM jumps from the current state directly to RESP with respProduct=0, respOverflow=0, respError=1.
- Latency from the accept edge to respValid: 5+SETTLE_CYCLES cycles (CLEAR_ON_START=1), or 4+SETTLE_CYCLES cycles (CLEAR_ON_START=0).
- Width: product is the low WIDTH bits as delivered by the multiplier. The sequencer performs no arithmetic.
- reqValid in a non-IDLE state is ignored; reqA/reqB changes after accept have no effect.

Decomposition:
- Shared package mul_seq_pkg holds:
  - the state enum (3-bit encoding, IDLE=0);
  - the SETTLE counter width constant (4);
  - the latency constant LAT_BASE=4.
- One natural sub-module: mul_seq_enable_decode, a combinational state → nine enable/reset outputs decoder.
- Datapath latches and FSM stay in the top module.

Test Plan:
- Basic multiply: A=3, B=7, SETTLE_CYCLES=1, respReady=1 → enable/reset pattern CLEAR, LOAD, SETTLE, CAPTURE, READ in consecutive cycles; respValid 6 cycles after accept with product 21, respOverflow=0, respError=0.
- Overflow: A=32'h0001_0000, B=32'h0001_0000 → respProduct=0, respOverflow=1; A=32'hFFFF_FFFF, B=2 → respProduct=32'hFFFF_FFFE, respOverflow=1.
- Response backpressure: respReady held 0 for 5 cycles → respValid and the data stay stable; reqReady=0 throughout; a new reqValid during RESP is not accepted until IDLE.
- Access error: force accessErrorB=1 during SETTLE → next state RESP, respProduct=0, respError=1; the next request A=2, B=5 returns 10 with respError=0.
- Async reset mid-op: drop resetN during CAPTURE → all enables 0 immediately, no respValid, reqReady=1 after release; a fresh request A=4, B=4 returns 16.
- Parameters: CLEAR_ON_START=0, SETTLE_CYCLES=3, A=6, B=9 → resetA/B/Out never asserted; readEnableA/B high for 4 cycles before readEnableOut; respValid 7 cycles after accept with product 54.
